// File: rtl/product_accumulator_if.sv
// Product-stream / result handshake bundle for product_accumulator.
// master = upstream/downstream environment, slave = the accumulator.
interface product_accumulator_if #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 72,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              busy;
    logic              prod_valid;
    logic [PROD_W-1:0] prod;
    logic              prod_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_valid;
    logic              acc_ready;
    logic              overflow;

    modport master (
        output start, len, prod_valid, prod, acc_ready,
        input  busy, prod_ready, acc_out, acc_valid, overflow
    );

    modport slave (
        input  start, len, prod_valid, prod, acc_ready,
        output busy, prod_ready, acc_out, acc_valid, overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// Accumulates a programmed number of signed products into one wide sum.
// Define ACC_SATURATION_EN to clamp on overflow instead of wrapping.
module product_accumulator #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 72,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    product_accumulator_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]         acc_out_q, acc_out_d;
    logic                     acc_valid_q, acc_valid_d;
    logic                     overflow_q, overflow_d;
    logic                     busy_q, busy_d;
    logic                     prod_ready_q, prod_ready_d;

    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  add_res;
    logic                     add_ovf;

    always_comb begin
        prod_ext = ACC_W'($signed(bus.prod));
        sum      = acc_q + prod_ext;
        // Overflow only when both operands share a sign the result lacks.
        add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef ACC_SATURATION_EN
        if (add_ovf) begin
            add_res = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            add_res = sum;
        end
`else
        add_res = sum;
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = acc_valid_q;
        overflow_d  = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d      = '0;
                    overflow_d = 1'b0;
                    if (bus.len != '0) begin
                        cnt_d   = bus.len;
                        state_d = ACCUM;
                    end else begin
                        cnt_d       = '0;
                        acc_out_d   = '0;
                        acc_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            ACCUM: begin
                if (bus.prod_valid && prod_ready_q) begin
                    acc_d      = add_res;
                    overflow_d = overflow_q | add_ovf;
                    cnt_d      = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        acc_out_d   = add_res;
                        acc_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (acc_valid_q && bus.acc_ready) begin
                    acc_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they align with it.
        busy_d       = (state_d != IDLE);
        prod_ready_d = (state_d == ACCUM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            acc_out_q    <= '0;
            acc_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            prod_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            acc_out_q    <= acc_out_d;
            acc_valid_q  <= acc_valid_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            prod_ready_q <= prod_ready_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.prod_ready = prod_ready_q;
    assign bus.acc_out    = acc_out_q;
    assign bus.acc_valid  = acc_valid_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a full-width instance plus an
// 8-bit instance for overflow behaviour.
module tb_product_accumulator;

    logic clk;
    logic rst;

    int total;
    int bad;

    product_accumulator_if #(.PROD_W(64), .ACC_W(72), .CNT_W(16)) bus ();
    product_accumulator_if #(.PROD_W(8),  .ACC_W(8),  .CNT_W(16)) b8 ();

    product_accumulator #(.PROD_W(64), .ACC_W(72), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    product_accumulator #(.PROD_W(8), .ACC_W(8), .CNT_W(16)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int p2 [4] = '{8, 0, 150, 220};
    logic [7:0] ovf_exp;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.start = 1'b0; bus.len = '0; bus.prod_valid = 1'b0; bus.prod = '0; bus.acc_ready = 1'b0;
        b8.start  = 1'b0; b8.len  = '0; b8.prod_valid  = 1'b0; b8.prod  = '0; b8.acc_ready  = 1'b0;
`ifdef ACC_SATURATION_EN
        ovf_exp = 8'h7F;
`else
        ovf_exp = 8'hC8;
`endif

        tick();
        tick();
        chk("rst_busy",      72'(bus.busy), 72'(0));
        chk("rst_ready",     72'(bus.prod_ready), 72'(0));
        chk("rst_acc_out",   bus.acc_out, 72'(0));
        chk("rst_acc_valid", 72'(bus.acc_valid), 72'(0));
        chk("rst_overflow",  72'(bus.overflow), 72'(0));
        rst = 1'b0;
        tick();

        // Back-to-back products.
        bus.start = 1'b1; bus.len = 16'd3;
        tick();
        bus.start = 1'b0;
        chk("t1_ready", 72'(bus.prod_ready), 72'(1));
        chk("t1_busy",  72'(bus.busy), 72'(1));
        bus.prod_valid = 1'b1; bus.prod = -1500;
        tick();
        chk("t1_valid_early1", 72'(bus.acc_valid), 72'(0));
        bus.prod = 100;
        tick();
        chk("t1_valid_early2", 72'(bus.acc_valid), 72'(0));
        bus.prod = -22500;
        tick();
        bus.prod_valid = 1'b0;
        chk("t1_acc_valid", 72'(bus.acc_valid), 72'(1));
        chk("t1_acc_out",   bus.acc_out, -72'sd23900);
        chk("t1_overflow",  72'(bus.overflow), 72'(0));
        chk("t1_ready_done", 72'(bus.prod_ready), 72'(0));
        bus.acc_ready = 1'b1;
        tick();
        bus.acc_ready = 1'b0;
        chk("t1_idle_valid", 72'(bus.acc_valid), 72'(0));
        chk("t1_idle_busy",  72'(bus.busy), 72'(0));
        chk("t1_hold_out",   bus.acc_out, -72'sd23900);

        // Gapped products.
        bus.start = 1'b1; bus.len = 16'd4;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_ready", 72'(bus.prod_ready), 72'(1));
            bus.prod_valid = 1'b1; bus.prod = 64'(p2[i]);
            tick();
            bus.prod_valid = 1'b0;
            if (i != 3) begin
                chk("t2_no_valid", 72'(bus.acc_valid), 72'(0));
                tick();
                chk("t2_ready_gap", 72'(bus.prod_ready), 72'(1));
            end
        end
        chk("t2_acc_valid", 72'(bus.acc_valid), 72'(1));
        chk("t2_acc_out",   bus.acc_out, 72'(378));
        chk("t2_ready_done", 72'(bus.prod_ready), 72'(0));
        bus.acc_ready = 1'b1;
        tick();
        bus.acc_ready = 1'b0;

        // Empty sum.
        bus.prod_valid = 1'b1; bus.prod = 64'd55;
        bus.start = 1'b1; bus.len = 16'd0;
        tick();
        bus.start = 1'b0;
        chk("t3_acc_valid", 72'(bus.acc_valid), 72'(1));
        chk("t3_acc_out",   bus.acc_out, 72'(0));
        chk("t3_ready",     72'(bus.prod_ready), 72'(0));
        chk("t3_busy",      72'(bus.busy), 72'(1));
        bus.prod_valid = 1'b0;
        bus.acc_ready = 1'b1;
        tick();
        bus.acc_ready = 1'b0;
        chk("t3_idle_busy", 72'(bus.busy), 72'(0));

        // Result held under back-pressure; start ignored outside IDLE.
        bus.start = 1'b1; bus.len = 16'd1;
        tick();
        bus.start = 1'b0;
        bus.prod_valid = 1'b1; bus.prod = 64'd777;
        tick();
        bus.prod_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.start = 1'b1; bus.len = 16'd2;
            chk("t4_hold_valid", 72'(bus.acc_valid), 72'(1));
            chk("t4_hold_out",   bus.acc_out, 72'(777));
            chk("t4_hold_ready", 72'(bus.prod_ready), 72'(0));
            tick();
        end
        bus.acc_ready = 1'b1;
        tick();
        chk("t4_accept_busy",  72'(bus.busy), 72'(0));
        chk("t4_accept_valid", 72'(bus.acc_valid), 72'(0));
        bus.start = 1'b0; bus.acc_ready = 1'b0;
        tick();
        chk("t4_start_ignored", 72'(bus.busy), 72'(0));
        chk("t4_out_held",      bus.acc_out, 72'(777));

        // Overflow on the 8-bit instance.
        b8.start = 1'b1; b8.len = 16'd2;
        tick();
        b8.start = 1'b0;
        b8.prod_valid = 1'b1; b8.prod = 8'd100;
        tick();
        tick();
        b8.prod_valid = 1'b0;
        chk("t5_overflow",  72'(b8.overflow), 72'(1));
        chk("t5_acc_out",   72'(b8.acc_out), 72'(ovf_exp));
        chk("t5_acc_valid", 72'(b8.acc_valid), 72'(1));
        b8.acc_ready = 1'b1;
        tick();
        b8.acc_ready = 1'b0;
        b8.start = 1'b1; b8.len = 16'd1;
        tick();
        b8.start = 1'b0;
        chk("t5_ovf_cleared", 72'(b8.overflow), 72'(0));
        b8.prod_valid = 1'b1; b8.prod = 8'd3;
        tick();
        b8.prod_valid = 1'b0;
        chk("t5_small_out", 72'(b8.acc_out), 72'(3));
        chk("t5_small_ovf", 72'(b8.overflow), 72'(0));
        b8.acc_ready = 1'b1;
        tick();
        b8.acc_ready = 1'b0;

        // Asynchronous reset mid-accumulation.
        bus.start = 1'b1; bus.len = 16'd3;
        tick();
        bus.start = 1'b0;
        bus.prod_valid = 1'b1; bus.prod = 64'd5;
        tick();
        bus.prod_valid = 1'b0;
        chk("t6_busy_before", 72'(bus.busy), 72'(1));
        rst = 1'b1;
        #1;
        chk("t6_rst_busy",      72'(bus.busy), 72'(0));
        chk("t6_rst_ready",     72'(bus.prod_ready), 72'(0));
        chk("t6_rst_acc_out",   bus.acc_out, 72'(0));
        chk("t6_rst_acc_valid", 72'(bus.acc_valid), 72'(0));
        chk("t6_rst_overflow",  72'(bus.overflow), 72'(0));
        #1;
        rst = 1'b0;
        tick();
        bus.start = 1'b1; bus.len = 16'd1;
        tick();
        bus.start = 1'b0;
        bus.prod_valid = 1'b1; bus.prod = -7;
        tick();
        bus.prod_valid = 1'b0;
        chk("t6_acc_out",   bus.acc_out, -72'sd7);
        chk("t6_overflow",  72'(bus.overflow), 72'(0));
        chk("t6_acc_valid", 72'(bus.acc_valid), 72'(1));
        bus.acc_ready = 1'b1;
        tick();
        bus.acc_ready = 1'b0;
        chk("t6_idle_busy", 72'(bus.busy), 72'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
